// File: rtl/uart_rx_deserializer.sv
// ============================================================================
// Module      : uart_rx_deserializer
// Description : 8N1 UART receiver with mid-bit sampling, false-start rejection
//               and framing check. Defining UART_RX_PARITY_EN switches to 8E1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [2:0] rx_state,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    // Encoding is shared with the transmit mux so both can be probed together.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_BIT = 3'd1,
        ST_RX_DATA   = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP_BIT  = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t           r_state_q,  w_state_d;
    logic [1:0]       r_sync_q;
    logic [CNT_W-1:0] r_cnt_q,    w_cnt_d;
    logic [2:0]       r_idx_q,    w_idx_d;
    logic [7:0]       r_shift_q,  w_shift_d;
    logic [7:0]       r_data_q,   w_data_d;
    logic             r_valid_q,  w_valid_d;
    logic             r_perr_q,   w_perr_d;
    logic             r_ferr_q,   w_ferr_d;
`ifdef UART_RX_PARITY_EN
    logic             r_par_q,    w_par_d;
`endif
    logic             w_rx_s;

    assign w_rx_s = r_sync_q[1];

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q + CNT_W'(1);
        w_idx_d   = r_idx_q;
        w_shift_d = r_shift_q;
        w_data_d  = r_data_q;
        w_valid_d = 1'b0;
        w_perr_d  = r_perr_q;
        w_ferr_d  = r_ferr_q;
`ifdef UART_RX_PARITY_EN
        w_par_d   = r_par_q;
`endif
        case (r_state_q)
            ST_IDLE: begin
                w_cnt_d = '0;
                if (!w_rx_s) begin
                    w_state_d = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                if (r_cnt_q == c_HALF_M1) begin
                    w_cnt_d = '0;
                    w_idx_d = 3'd0;
                    // A line that is already high again at mid-start is noise.
                    w_state_d = w_rx_s ? ST_IDLE : ST_RX_DATA;
                end
            end
            ST_RX_DATA: begin
                if (r_cnt_q == c_FULL_M1) begin
                    w_cnt_d            = '0;
                    w_shift_d[r_idx_q] = w_rx_s;
                    w_idx_d            = r_idx_q + 3'd1;
                    if (r_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_d = ST_PARITY;
`else
                        w_state_d = ST_STOP_BIT;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (r_cnt_q == c_FULL_M1) begin
                    w_cnt_d   = '0;
                    w_par_d   = w_rx_s;
                    w_state_d = ST_STOP_BIT;
                end
            end
`endif
            ST_STOP_BIT: begin
                if (r_cnt_q == c_FULL_M1) begin
                    w_cnt_d   = '0;
                    w_data_d  = r_shift_q;
                    w_valid_d = 1'b1;
                    w_ferr_d  = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                    w_perr_d  = (^r_shift_q) ^ r_par_q;
`else
                    w_perr_d  = 1'b0;
`endif
                    w_state_d = w_rx_s ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                // Hold here so a stuck-low line yields one frame, not many.
                w_cnt_d = '0;
                if (w_rx_s) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_sync_q  <= 2'b11;
            r_cnt_q   <= '0;
            r_idx_q   <= 3'd0;
            r_shift_q <= 8'h00;
            r_data_q  <= 8'h00;
            r_valid_q <= 1'b0;
            r_perr_q  <= 1'b0;
            r_ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_sync_q  <= {r_sync_q[0], rx};
            r_cnt_q   <= w_cnt_d;
            r_idx_q   <= w_idx_d;
            r_shift_q <= w_shift_d;
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_perr_q  <= w_perr_d;
            r_ferr_q  <= w_ferr_d;
`ifdef UART_RX_PARITY_EN
            r_par_q   <= w_par_d;
`endif
        end
    end

    assign rx_data    = r_data_q;
    assign rx_valid   = r_valid_q;
    assign parity_err = r_perr_q;
    assign frame_err  = r_ferr_q;
    assign rx_state   = r_state_q;
    assign busy       = (r_state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
// ============================================================================
// Module      : tb_uart_rx_deserializer
// Description : Scoreboard bench for uart_rx_deserializer (CLKS_PER_BIT=16);
//               honours UART_RX_PARITY_EN for the 8E1 frame format.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_deserializer;

    localparam int    c_CPB      = 16;
    localparam real   c_CLK_NS   = 10.0;
    localparam real   c_BIT_NS   = c_CLK_NS * c_CPB;
`ifdef UART_RX_PARITY_EN
    localparam int    c_STOP_SLOT = 10;
    localparam bit    c_PAR_EN    = 1'b1;
`else
    localparam int    c_STOP_SLOT = 9;
    localparam bit    c_PAR_EN    = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic [2:0] rx_state;
    logic       busy;

    uart_rx_deserializer #(.CLKS_PER_BIT(c_CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_state   (rx_state),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #(c_CLK_NS / 2.0) clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        int         at_cyc;   // -1 when the frame is not clock-aligned
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transmitter model: drives one frame with the given bit time and queues
    // what a correct receiver must report for it.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok,
                              input real bit_ns, input bit timed);
        exp_t e;
        logic pbit;
        pbit     = (^d) ^ ~par_ok;
        e.data   = d;
        e.ferr   = ~stop;
        e.perr   = c_PAR_EN ? ~par_ok : 1'b0;
        e.at_cyc = timed ? cyc + 3 + c_CPB / 2 + c_STOP_SLOT * c_CPB : -1;
        sb.push_back(e);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        if (c_PAR_EN) begin
            rx = pbit;
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (rx_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_strobe", 32'(rx_data), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rx_data", 32'(rx_data), 32'(e.data));
                        check("frame_err", 32'(frame_err), 32'(e.ferr));
                        check("parity_err", 32'(parity_err), 32'(e.perr));
                        if (e.at_cyc >= 0)
                            check("strobe_cycle", 32'(cyc), 32'(e.at_cyc));
                    end
                end
            end
        join_none

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_rx_state", 32'(rx_state), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        align();
        rst = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("idle_state", 32'(rx_state), 32'h0);

        // Single frame at nominal rate, clock-aligned so latency is exact
        align();
        send_frame(8'hA5, 1'b1, 1'b1, c_BIT_NS, 1'b1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("after_a5_state", 32'(rx_state), 32'h0);
        check("after_a5_busy", 32'(busy), 32'h0);

        // Short low glitch: false start, outputs untouched
        align();
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("glitch_state", 32'(rx_state), 32'h0);
        check("glitch_rx_data", 32'(rx_data), 32'hA5);

        // Framing error with the line left low
        align();
        send_frame(8'h3C, 1'b0, 1'b1, c_BIT_NS, 1'b1);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("break_state", 32'(rx_state), 32'h5);
        check("break_busy", 32'(busy), 32'h1);
        check("break_rx_data", 32'(rx_data), 32'h3C);
        align();
        rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("break_release_state", 32'(rx_state), 32'h0);

`ifdef UART_RX_PARITY_EN
        align();
        send_frame(8'h81, 1'b1, 1'b1, c_BIT_NS, 1'b1);
        send_frame(8'h81, 1'b1, 1'b0, c_BIT_NS, 1'b1);
        repeat (20) @(posedge clk);
`endif

        // Randomized frames: data, +/-2% baud error, gaps, occasional breaks
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       stop;
            logic       pok;
            real        bit_ns;
            d      = 8'($urandom);
            stop   = ($urandom_range(0, 7) != 0);
            pok    = ($urandom_range(0, 3) != 0);
            bit_ns = c_BIT_NS * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
            if ($urandom_range(0, 1) == 1) begin
                rx = 1'b1;
                #(real'($urandom_range(1, 300)));
            end
            send_frame(d, stop, pok, bit_ns, 1'b0);
            if (!stop) begin
                rx = 1'b1;
                #(2.0 * bit_ns);
            end
        end
        rx = 1'b1;
        repeat (40) @(posedge clk);

        // Back-to-back frames with no idle gap
        align();
        send_frame(8'h00, 1'b1, 1'b1, c_BIT_NS, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1, c_BIT_NS, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1, c_BIT_NS, 1'b1);
        repeat (40) @(posedge clk);

        // Reset in the middle of data bit 4
        align();
        begin
            logic [7:0] d;
            d = 8'h5A;
            rx = 1'b0;
            #(c_BIT_NS);
            for (int i = 0; i < 4; i++) begin
                rx = d[i];
                #(c_BIT_NS);
            end
            rx = d[4];
            #(c_BIT_NS / 2.0);
        end
        @(negedge clk);
        check("midframe_state", 32'(rx_state), 32'h2);
        check("midframe_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(rx_state), 32'h0);
        check("abort_rx_data", 32'(rx_data), 32'h00);
        check("abort_rx_valid", 32'(rx_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        repeat (300) @(posedge clk);
        @(negedge clk);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-side counterpart of the UART transmit path. Recovers 8N1 frames, or 8E1 frames when parity is compiled in, from the asynchronous `rx` line. It synchronizes the line, detects and validates the start bit, samples each bit at mid-period, and presents the byte with error flags and a one-cycle valid strobe to the register or bus interface. The state encoding matches the transmit mux, so TX and RX state can be probed side by side.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 5208 (50 MHz / 9600 baud): `clk` cycles per bit. Legal values are even and ≥ 4.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `rx`, in, 1: asynchronous serial line; idle high.
- `rx_data`, out, 8: last received byte, LSB received first.
- `rx_valid`, out, 1: one-cycle strobe; a frame completed.
- `parity_err`, out, 1: parity mismatch on last frame.
- `frame_err`, out, 1: stop bit sampled low on last frame.
- `rx_state`, out, 3: current FSM state (debug).
- `busy`, out, 1: high whenever `rx_state` != IDLE.

## Operation
- **Input synchronizer:** two-flop synchronizer `rx` → `rx_s`, reset to 1. All decisions use `rx_s` only.
- **State encoding:** IDLE=0, START_BIT=1, RX_DATA=2, PARITY_BIT=3, STOP_BIT=4, WAIT_IDLE=5. Unused codes go to IDLE.
- **Counters:** tick counter `cnt` (width `$clog2(CLKS_PER_BIT)`), zeroed on every state entry and after every sample; 3-bit bit index, zeroed on entry to RX_DATA.
- **IDLE:** when `rx_s`=0, go to START_BIT.
- **START_BIT:** at `cnt`==`CLKS_PER_BIT/2-1`, sample.
  - If `rx_s`=1, this is a false start: go to IDLE with no strobe and no flag change.
  - Otherwise go to RX_DATA.
- **RX_DATA:** at `cnt`==`CLKS_PER_BIT-1`, shift `rx_s` into bit[index] of a shift register and increment the index. After index 7, go to PARITY_BIT if parity is enabled, otherwise STOP_BIT.
- **PARITY_BIT:** at `cnt`==`CLKS_PER_BIT-1`, capture the bit and go to STOP_BIT.
- **STOP_BIT:** at `cnt`==`CLKS_PER_BIT-1`, sample and update the outputs on the next edge:
  - `rx_data` is loaded.
  - `rx_valid` is 1 for exactly one cycle.
  - `frame_err` is set to the inverse of the stop sample.
  - `parity_err` is set to (XOR of data and parity bit) != 0 (even parity).
  - If stop=1, go to IDLE; a new start may be detected on the next cycle.
  - If stop=0 (break or framing error), go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- **Output hold:** `rx_data`, `parity_err` and `frame_err` are held until the next completed frame. A false start does not alter them.
- **Status during reception:** `rx_data` is not updated mid-frame. `busy` = (`rx_state` != 0).

## Timing
- **Reset values:**
  - `rx_data`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `rx_state`=0, `busy`=0.
  - Synchronizer flops=1; counters=0.
- **Reset priority:** reset mid-frame aborts immediately to IDLE with no strobe. Reset wins over any simultaneous sample event.
- **Cycle numbering:** let cycle 0 be the edge where IDLE sees `rx_s`=0. That edge is 2 cycles after `rx` falls, due to the synchronizer.
  - Start sample: cycle `CLKS_PER_BIT/2`.
  - Data bit k (0..7) sample: cycle `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
  - Parity sample: k=8 slot.
  - Stop sample: slot 9 (no parity) or slot 10 (parity).
  - `rx_valid` is high in the cycle after the stop sample.
- **Back-to-back frames:** a start edge arriving half a bit after the stop sample is detected without loss. Continuous frames at nominal baud are received with no gaps.
- **Baud tolerance:** frames are received correctly with up to ±2% transmitter baud error.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - The frame is start + 8 data + even parity + stop; the PARITY_BIT state is used.
  - `parity_err` is computed as above.
- **Not defined:**
  - The frame is start + 8 data + stop (8N1). PARITY_BIT is unreachable; RX_DATA goes directly to STOP_BIT.
  - `parity_err` is constant 0.
- The value must match the transmit side's build setting.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **Reset and idle:** assert `rst` for 3 cycles with `rx`=1 → all outputs 0, `rx_state`=0; line held high for 200 cycles gives no `rx_valid`.
- **Single frame:** send 0xA5, 8N1 → one `rx_valid` pulse 2+8+9·16+1 cycles after the falling edge, `rx_data`=0xA5, both error flags 0.
- **Glitch:** drive `rx` low for 5 cycles, then high → false start; return to IDLE with no strobe; `rx_data` unchanged.
- **Framing error:** send 0x3C with stop bit 0, then hold the line low for 100 cycles → one strobe with `frame_err`=1 and `rx_data`=0x3C; stay in WAIT_IDLE (5) until the line goes high; no second strobe.
- **Parity (`UART_RX_PARITY_EN`):** 0x81 with parity 0 gives `parity_err`=0; 0x81 with parity 1 gives `parity_err`=1.
- **Back-to-back and reset abort:** send 0x00, 0xFF, 0x55 with no idle gap → 3 strobes with correct data. Then assert `rst` during data bit 4 → no strobe, FSM in IDLE, `rx_data` at reset value 0x00.
